// File: rtl/co_b_rom_fetch_ctrl_pkg.sv
// Shared definitions for the coefficient-B ROM burst fetch controller.
package co_b_rom_fetch_ctrl_pkg;

    // Default geometry of the co_B coefficient ROM and its read path.
    localparam int CO_B_ADDR_W     = 10;
    localparam int CO_B_DATA_W     = 16;
    localparam int CO_B_ROM_LAT    = 1;
    localparam int CO_B_FIFO_DEPTH = 4;

    // Burst sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/co_b_rom_fetch_ctrl_coef_fifo.sv
// Synchronous FIFO buffering returned ROM words (data plus last tag) ahead of
// the coefficient stream. Simultaneous write and read are supported; the
// caller never writes when full nor reads when empty.
module co_b_coef_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 17,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Storage write.
    // NOTE: the storage array has no reset; only pointers and count define
    // which entries are meaningful, so clearing the array would be wasted logic.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy tracking.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
    assign empty   = (count == '0);

endmodule

// File: rtl/co_b_rom_fetch_ctrl.sv
// Burst-read sequencer for the co_B coefficient ROM. Accepts a start command
// (base, length), issues one ROM read per cycle while buffer credit allows,
// tracks the ROM latency with a valid/last pipe, and presents the returned
// words as a valid/ready stream with a last flag.
module co_b_rom_fetch_ctrl
    import co_b_rom_fetch_ctrl_pkg::*;
#(
    parameter int ADDR_W     = CO_B_ADDR_W,
    parameter int DATA_W     = CO_B_DATA_W,
    parameter int ROM_LAT    = CO_B_ROM_LAT,
    parameter int FIFO_DEPTH = CO_B_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W:0]   len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              rom_en_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [DATA_W-1:0] rom_data_i,
    output logic [DATA_W-1:0] coef_o,
    output logic              coef_val_o,
    input  logic              coef_rdy_i,
    output logic              coef_last_o
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int OCC_W = CNT_W + 1;

    fetch_state_e      state_q;
    fetch_state_e      state_d;
    logic              done_q;
    logic              done_d;
    logic              accept;
    logic              issue;
    logic              issue_last;
    logic              credit_ok;
    logic              pop;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] last_addr_q;
    logic [ADDR_W-1:0] issue_addr;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   issued_q;
    logic [ROM_LAT-1:0] vld_pipe;
    logic [ROM_LAT-1:0] last_pipe;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W-1:0]  inflight;
    logic              fifo_empty;
    logic              rd_last;
    logic [DATA_W-1:0] rd_data;

    // Address of the next read wraps naturally at the ROM size.
    assign issue_addr = base_q + issued_q[ADDR_W-1:0];
    assign issue_last = (issued_q == len_q - (ADDR_W+1)'(1));
    assign accept     = (state_q == ST_IDLE) && start_i && !done_q;
    assign pop        = coef_val_o && coef_rdy_i;

    // Count reads still travelling through the ROM latency pipe.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < ROM_LAT; i++) begin
            inflight = inflight + CNT_W'(vld_pipe[i]);
        end
    end

    // A read may issue only if a FIFO slot is guaranteed for its return word.
    assign credit_ok = ({1'b0, fifo_count} + {1'b0, inflight}) < OCC_W'(FIFO_DEPTH);

    // Next-state and issue decision.
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        issue   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (len_i != '0) state_d = ST_FETCH;
                    else             done_d  = 1'b1;
                end
            end
            ST_FETCH: begin
                if (credit_ok) begin
                    issue = 1'b1;
                    if (issue_last) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pop && rd_last) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and completion-pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    // Command capture, issue counter and last issued address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q      <= '0;
            len_q       <= '0;
            issued_q    <= '0;
            last_addr_q <= '0;
        end else begin
            if (accept) begin
                base_q   <= base_addr_i;
                len_q    <= len_i;
                issued_q <= '0;
            end else if (issue) begin
                issued_q <= issued_q + (ADDR_W+1)'(1);
            end
            if (issue) begin
                last_addr_q <= issue_addr;
            end
        end
    end

    // Valid/last tags aligned with the ROM read latency; cleared on reset so
    // any data still returning from an aborted burst is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
        end else begin
            vld_pipe[0]  <= issue;
            last_pipe[0] <= issue && issue_last;
            for (int i = 1; i < ROM_LAT; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                last_pipe[i] <= last_pipe[i-1];
            end
        end
    end

    co_b_coef_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W + 1)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (vld_pipe[ROM_LAT-1]),
        .wr_data ({last_pipe[ROM_LAT-1], rom_data_i}),
        .rd_en   (pop),
        .rd_data ({rd_last, rd_data}),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign coef_val_o  = !fifo_empty;
    assign coef_o      = coef_val_o ? rd_data : '0;
    assign coef_last_o = coef_val_o && rd_last;
    assign rom_en_o    = issue;
    assign rom_addr_o  = issue ? issue_addr : last_addr_q;
    assign busy_o      = (state_q != ST_IDLE) || done_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_co_b_rom_fetch_ctrl.sv
// Scoreboard bench for co_b_rom_fetch_ctrl with a registered ROM model
// (word[a] = a ^ 16'h5A5A, one cycle latency).
module tb_co_b_rom_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  base;
    logic [10:0] len;
    logic        busy;
    logic        done;
    logic        rom_en;
    logic [9:0]  rom_addr;
    logic [15:0] rom_q;
    logic [15:0] coef;
    logic        coef_val;
    logic        coef_rdy;
    logic        coef_last;

    int n_cmp = 0;
    int n_err = 0;

    logic [9:0]  exp_addr_q[$];
    logic [16:0] exp_word_q[$];

    int cyc_cnt = 0, en_cnt = 0, xfer_cnt = 0, done_cnt = 0;
    int first_en, last_en, first_x, last_x, last_tag_cyc, done_cyc, max_out;

    co_b_rom_fetch_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start),
        .base_addr_i (base),
        .len_i       (len),
        .busy_o      (busy),
        .done_o      (done),
        .rom_en_o    (rom_en),
        .rom_addr_o  (rom_addr),
        .rom_data_i  (rom_q),
        .coef_o      (coef),
        .coef_val_o  (coef_val),
        .coef_rdy_i  (coef_rdy),
        .coef_last_o (coef_last)
    );

    always #5 clk = ~clk;

    // Registered ROM model.
    always @(posedge clk) begin
        if (rom_en) rom_q <= 16'(rom_addr) ^ 16'h5A5A;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Monitor: sample away from the rising edge, score issues and transfers.
    always @(negedge clk) begin
        if (!rst) begin
            cyc_cnt++;
            if (rom_en) begin
                en_cnt++;
                if (first_en < 0) first_en = cyc_cnt;
                last_en = cyc_cnt;
                check("addr_expected", 32'(exp_addr_q.size() != 0), 32'd1);
                if (exp_addr_q.size() != 0) check("rom_addr", 32'(rom_addr), 32'(exp_addr_q.pop_front()));
            end
            if (coef_val && coef_rdy) begin
                logic [16:0] w;
                xfer_cnt++;
                if (first_x < 0) first_x = cyc_cnt;
                last_x = cyc_cnt;
                if (coef_last) last_tag_cyc = cyc_cnt;
                check("word_expected", 32'(exp_word_q.size() != 0), 32'd1);
                if (exp_word_q.size() != 0) begin
                    w = exp_word_q.pop_front();
                    check("coef", 32'(coef), 32'(w[15:0]));
                    check("coef_last", 32'(coef_last), 32'(w[16]));
                end
            end
            if (en_cnt - xfer_cnt > max_out) max_out = en_cnt - xfer_cnt;
            if (done) begin
                done_cnt++;
                done_cyc = cyc_cnt;
                check("busy_in_done", 32'(busy), 32'd1);
            end
        end
    end

    task automatic start_cmd(input logic [9:0] b, input logic [10:0] l);
        logic [9:0] a;
        @(posedge clk); #1;
        start = 1'b1;
        base  = b;
        len   = l;
        for (int i = 0; i < int'(l); i++) begin
            a = b + 10'(i);
            exp_addr_q.push_back(a);
            exp_word_q.push_back({i == int'(l) - 1, 16'(a) ^ 16'h5A5A});
        end
        @(posedge clk); #1;
        start = 1'b0;
        base  = 10'($urandom);
        len   = 11'($urandom);
    endtask

    // mode 0: rdy held high; 1: rdy toggles; 2: rdy low 20 cycles then toggles.
    task automatic run_burst(input logic [9:0] b, input logic [10:0] l, input int mode, input bit inject);
        int d0, e0, x0, cyc;
        d0 = done_cnt; e0 = en_cnt; x0 = xfer_cnt;
        first_en = -1; first_x = -1; max_out = 0;
        coef_rdy = 1'b1;
        start_cmd(b, l);
        cyc = 0;
        while (done_cnt == d0 && cyc < 5000) begin
            case (mode)
                1:       coef_rdy = (cyc % 2) == 0;
                2:       coef_rdy = (cyc >= 20) && ((cyc % 2) == 0);
                default: coef_rdy = 1'b1;
            endcase
            if (inject && cyc == 3) begin
                start = 1'b1; base = 10'h200; len = 11'd5;
            end else if (inject && cyc == 4) begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        coef_rdy = 1'b1;
        start    = 1'b0;
        check("burst_done_seen", 32'(done_cnt != d0), 32'd1);
        @(negedge clk);
        check("busy_after_done", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        check("done_pulses", 32'(done_cnt - d0), 32'd1);
        check("reads_issued", 32'(en_cnt - e0), 32'(l));
        check("words_moved", 32'(xfer_cnt - x0), 32'(l));
        check("words_left", 32'(exp_word_q.size()), 32'd0);
        check("max_outstanding_le4", 32'(max_out <= 4), 32'd1);
        check("done_after_last", 32'(done_cyc), 32'(last_tag_cyc + 1));
        if (mode == 0) begin
            check("issue_span", 32'(last_en - first_en + 1), 32'(l));
            check("xfer_span", 32'(last_x - first_x + 1), 32'(l));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0, e0, x0, cyc;
        rst = 1'b1; start = 1'b0; base = '0; len = '0; coef_rdy = 1'b1;
        first_en = -1; first_x = -1; max_out = 0;
        last_tag_cyc = 0; done_cyc = 0; last_en = 0; last_x = 0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rom_en", 32'(rom_en), 32'd0);
        check("rst_coef_val", 32'(coef_val), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        run_burst(10'h010, 11'd8, 0, 1'b1);   // basic, with start while busy
        run_burst(10'h3FE, 11'd4, 0, 1'b0);   // address wrap
        run_burst(10'h000, 11'd16, 1, 1'b0);  // toggling ready
        run_burst(10'h000, 11'd16, 2, 1'b0);  // long stall then toggling

        // Zero-length command, plus a start during its done cycle.
        d0 = done_cnt; e0 = en_cnt;
        @(posedge clk); #1;
        start = 1'b1; base = 10'h055; len = 11'd0;
        @(posedge clk); #1;
        start = 1'b1; base = 10'h020; len = 11'd3;
        @(negedge clk);
        check("len0_done", 32'(done), 32'd1);
        check("len0_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("len0_busy_low", 32'(busy), 32'd0);
        check("len0_done_low", 32'(done), 32'd0);
        repeat (8) @(negedge clk);
        check("len0_no_reads", 32'(en_cnt - e0), 32'd0);
        check("len0_one_done", 32'(done_cnt - d0), 32'd1);

        run_burst(10'h000, 11'd1024, 0, 1'b0);  // full address space

        // Reset mid-burst after 10 transfers.
        coef_rdy = 1'b1;
        x0 = xfer_cnt;
        start_cmd(10'h040, 11'd32);
        cyc = 0;
        while (xfer_cnt - x0 < 10 && cyc < 200) begin
            @(negedge clk); #1;
            cyc++;
        end
        check("mid_ten_xfers", 32'(xfer_cnt - x0), 32'd10);
        d0 = done_cnt;
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_rom_en", 32'(rom_en), 32'd0);
        check("abort_rom_addr", 32'(rom_addr), 32'd0);
        check("abort_coef_val", 32'(coef_val), 32'd0);
        check("abort_coef", 32'(coef), 32'd0);
        check("abort_coef_last", 32'(coef_last), 32'd0);
        exp_addr_q.delete();
        exp_word_q.delete();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        run_burst(10'h100, 11'd2, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
